// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared ring/control-event types, slot constants and read-word layout
package ring_pkg;

    // Slot-type codes carried on the ring
    localparam logic [3:0] SLOT_NULL    = 4'd7;
    localparam logic [3:0] SLOT_TOKEN   = 4'd1;
    localparam logic [3:0] SLOT_MESSAGE = 4'd8;

    // One buffered control event
    typedef struct packed {
        logic [3:0] typ;
        logic [3:0] src;
    } ctrl_evt_t;

    // Field offsets inside the 32-bit poll word
    localparam int RD_VALID_BIT = 31;
    localparam int RD_COUNT_LSB = 16;
    localparam int RD_DROP_LSB  = 8;
    localparam int RD_TYPE_LSB  = 4;
    localparam int RD_SRC_LSB   = 0;

    // CPU-side handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_WMASK = 2'd2
    } evq_state_t;

endpackage

// File: rtl/ctrl_evq_fifo.sv
// rtl/ctrl_evq_fifo.sv - first-word-fall-through event FIFO with push/pop/flush
module ctrl_evq_fifo
    import ring_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  ctrl_evt_t  wdata,
    output ctrl_evt_t  head,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ctrl_evt_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A pop on a full FIFO frees the slot a same-cycle push needs; flush beats both
    always_comb begin
        do_pop   = pop & ~flush & (count_q != '0);
        do_push  = push & ~flush & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset so it maps onto distributed RAM
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/ctrl_event_queue.sv
// rtl/ctrl_event_queue.sv - control-message event queue polled over local I/O; CTRL_EVQ_DROPCNT_EN adds drop counter
module ctrl_event_queue
    import ring_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] aq,
    input  logic        read,
    input  logic [31:0] wq,
    input  logic        selCtrl,
    input  logic        ctrlValid,
    input  logic [3:0]  ctrlType,
    input  logic [3:0]  ctrlSrc,
    output logic [31:0] rqCtrl,
    output logic        wrq,
    output logic        rwq,
    output logic        done,
    output logic        evPending
);

    evq_state_t  state_q, state_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [15:0] type_mask_q, type_mask_d;

    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    ctrl_evt_t   fifo_head;
    ctrl_evt_t   fifo_wdata;
    logic [8:0]  cnt_minus1;
    logic [7:0]  drop_field;
    logic        unused_inputs;

    assign unused_inputs = ^{aq, wq[31:17]};

    assign fifo_wdata = '{typ: ctrlType, src: ctrlSrc};
    assign fifo_push  = ctrlValid & type_mask_q[ctrlType];
    assign fifo_pop   = (state_q == ST_IDLE) & selCtrl & read & ~fifo_empty;
    assign fifo_flush = (state_q == ST_WMASK) & wq[16];
    assign cnt_minus1 = 9'(fifo_count) - 9'd1;

    ctrl_evq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef CTRL_EVQ_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    // Overflow counter saturates; the response cycle hands it to software and restarts it
    always_comb begin
        drop       = fifo_push & fifo_full & ~fifo_pop;
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_RESP)
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        else if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
        drop_field = drop_cnt_q;
    end

    // Drop counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) drop_cnt_q <= 8'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end
`else
    logic unused_full;

    assign unused_full = fifo_full;
    assign drop_field  = 8'd0;
`endif

    // Request decode, poll-word assembly and one-cycle response pulses
    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        type_mask_d = type_mask_q;
        rqCtrl      = 32'd0;
        wrq         = 1'b0;
        rwq         = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (selCtrl) begin
                    if (read) begin
                        state_d   = ST_RESP;
                        rd_data_d = 32'd0;
                        rd_data_d[RD_DROP_LSB +: 8] = drop_field;
                        if (!fifo_empty) begin
                            rd_data_d[RD_VALID_BIT]      = 1'b1;
                            rd_data_d[RD_COUNT_LSB +: 8] = cnt_minus1[7:0];
                            rd_data_d[RD_TYPE_LSB +: 4]  = fifo_head.typ;
                            rd_data_d[RD_SRC_LSB +: 4]   = fifo_head.src;
                        end
                    end else begin
                        state_d = ST_WMASK;
                    end
                end
            end
            ST_RESP: begin
                wrq     = 1'b1;
                done    = 1'b1;
                rqCtrl  = rd_data_q;
                state_d = ST_IDLE;
            end
            ST_WMASK: begin
                rwq         = 1'b1;
                done        = 1'b1;
                type_mask_d = wq[15:0];
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, latched poll word and type mask
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_data_q   <= 32'd0;
            type_mask_q <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            type_mask_q <= type_mask_d;
        end
    end

    assign evPending = (fifo_count != '0);

endmodule

// File: tb/tb_ctrl_event_queue.sv
// tb/tb_ctrl_event_queue.sv - self-checking bench for ctrl_event_queue
module tb_ctrl_event_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] aq;
    logic        read;
    logic [31:0] wq;
    logic        selCtrl;
    logic        ctrlValid;
    logic [3:0]  ctrlType;
    logic [3:0]  ctrlSrc;
    logic [31:0] rqCtrl;
    logic        wrq, rwq, done, evPending;

    int tests = 0;
    int fails = 0;

    ctrl_event_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clk),
        .reset     (rst),
        .aq        (aq),
        .read      (read),
        .wq        (wq),
        .selCtrl   (selCtrl),
        .ctrlValid (ctrlValid),
        .ctrlType  (ctrlType),
        .ctrlSrc   (ctrlSrc),
        .rqCtrl    (rqCtrl),
        .wrq       (wrq),
        .rwq       (rwq),
        .done      (done),
        .evPending (evPending)
    );

    always #5 clk = ~clk;

    // Transaction-level model: event list, mask, overflow tally, pending response
    logic [7:0]  m_q[$];
    logic [15:0] m_mask = 16'hFFFF;
    int          m_drops = 0;
    bit          m_resp = 0;
    bit          m_wmask = 0;
    logic [31:0] m_word = 32'd0;

    function automatic logic [7:0] m_dfield();
`ifdef CTRL_EVQ_DROPCNT_EN
        return 8'(m_drops);
`else
        return 8'd0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_mask  = 16'hFFFF;
            m_drops = 0;
            m_resp  = 0;
            m_wmask = 0;
            m_word  = 32'd0;
        end else begin
            bit nr, nw, popd, dropped;
            logic [31:0] nword;
            nr = 0; nw = 0; popd = 0; dropped = 0; nword = m_word;
            if (!m_resp && !m_wmask && selCtrl) begin
                if (read) begin
                    nr = 1;
                    if (m_q.size() > 0) begin
                        nword = {8'h80, 8'(m_q.size() - 1), m_dfield(), m_q[0]};
                        popd = 1;
                    end else begin
                        nword = {16'h0, m_dfield(), 8'h00};
                    end
                end else begin
                    nw = 1;
                end
            end
            if (m_wmask && wq[16]) begin
                m_q.delete();
            end else begin
                if (popd) void'(m_q.pop_front());
                if (ctrlValid && m_mask[ctrlType]) begin
                    if (m_q.size() < DEPTH) m_q.push_back({ctrlType, ctrlSrc});
                    else dropped = 1;
                end
            end
            if (m_resp) m_drops = dropped ? 1 : 0;
            else if (dropped && m_drops < 255) m_drops++;
            if (m_wmask) m_mask = wq[15:0];
            m_resp  = nr;
            m_wmask = nw;
            m_word  = nword;
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        logic [35:0] act, exp;
        act = {wrq, done, rwq, evPending, rqCtrl};
        exp = {m_resp, m_resp | m_wmask, m_wmask, m_q.size() != 0, m_resp ? m_word : 32'd0};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cycle_model t=%0t: got wrq/done/rwq/pend/rq=%b%b%b%b/%h expected %b%b%b%b/%h",
                     $time, act[35], act[34], act[33], act[32], act[31:0],
                     exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] t, input logic [3:0] s);
        @(negedge clk);
        ctrlValid = 1'b1; ctrlType = t; ctrlSrc = s;
        @(negedge clk);
        ctrlValid = 1'b0;
    endtask

    task automatic cpu_read(output logic [31:0] w, output int lat);
        int n;
        @(negedge clk);
        selCtrl = 1'b1; read = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 8);
        if (!done) begin
            tests++; fails++;
            $display("FAIL read_timeout: got no done expected done within 8 cycles");
        end
        w = rqCtrl; lat = n;
        selCtrl = 1'b0; read = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] v, output int pulses);
        int n;
        @(negedge clk);
        selCtrl = 1'b1; read = 1'b0; wq = v; n = 0; pulses = 0;
        do begin
            @(negedge clk);
            n++;
            if (rwq) pulses++;
        end while (!done && n < 8);
        if (!done) begin
            tests++; fails++;
            $display("FAIL write_timeout: got no done expected done within 8 cycles");
        end
        selCtrl = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rwq) pulses++;
        end
        wq = 32'd0;
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  exp_drop;
        int lat, pulses;

        rst = 1'b0; aq = 14'h0; read = 1'b0; wq = 32'd0; selCtrl = 1'b0;
        ctrlValid = 1'b0; ctrlType = 4'd0; ctrlSrc = 4'd0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {28'd0, wrq, done, rwq, evPending}, 32'd0);
        check("reset_rq", rqCtrl, 32'd0);
        rst = 1'b0;

        // T1: read of empty queue
        cpu_read(w, lat);
        check("t1_latency", 32'(lat), 32'd1);
        check("t1_word", w, 32'h0000_0000);
        check("t1_pending", {31'd0, evPending}, 32'd0);

        // T2: single event round trip
        push(4'd3, 4'd5);
        check("t2_pending_set", {31'd0, evPending}, 32'd1);
        cpu_read(w, lat);
        check("t2_word", w, 32'h8000_0035);
        check("t2_pending_clr", {31'd0, evPending}, 32'd0);

        // T3: mask allows type 2 only
        cpu_write(32'h0000_0004, pulses);
        check("t3_rwq_pulses", 32'(pulses), 32'd1);
        push(4'd2, 4'd1);
        push(4'd3, 4'd1);
        cpu_read(w, lat);
        check("t3_word", w, 32'h8000_0021);
        cpu_read(w, lat);
        check("t3_empty_after", w, 32'h0000_0000);
        cpu_write(32'h0000_FFFF, pulses);

        // T4: 18 pushes into 16 slots
        for (int i = 0; i < 18; i++) push(4'(i), ~4'(i));
`ifdef CTRL_EVQ_DROPCNT_EN
        exp_drop = 8'h02;
`else
        exp_drop = 8'h00;
`endif
        cpu_read(w, lat);
        check("t4_word1", w, {8'h80, 8'h0F, exp_drop, 8'h0F});
        cpu_read(w, lat);
        check("t4_word2", w, 32'h800E_001E);

        // T5: refill to full, then push and pop in the same cycle
        push(4'hA, 4'h1);
        push(4'hB, 4'h2);
        @(negedge clk);
        ctrlValid = 1'b1; ctrlType = 4'hC; ctrlSrc = 4'h3;
        selCtrl = 1'b1; read = 1'b1;
        @(negedge clk);
        ctrlValid = 1'b0;
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_word", rqCtrl, 32'h800F_002D);
        selCtrl = 1'b0; read = 1'b0;
        cpu_read(w, lat);
        check("t5_count_kept", w, 32'h800F_003C);
        for (int i = 0; i < 15; i++) cpu_read(w, lat);
        check("t5_last", w, 32'h8000_00C3);
        check("t5_drained", {31'd0, evPending}, 32'd0);

        // T6: flush with mask reload
        for (int i = 0; i < 5; i++) push(4'(i), 4'd9);
        cpu_write(32'h0001_0010, pulses);
        check("t6_flushed", {31'd0, evPending}, 32'd0);
        push(4'd3, 4'd7);
        push(4'd4, 4'd7);
        cpu_read(w, lat);
        check("t6_word", w, 32'h8000_0047);

        // Reset in the middle of a response
        push(4'd4, 4'd2);
        @(negedge clk);
        selCtrl = 1'b1; read = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pre_done", {31'd0, done}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {28'd0, wrq, done, rwq, evPending}, 32'd0);
        check("rst_mid_rq", rqCtrl, 32'd0);
        @(negedge clk);
        selCtrl = 1'b0; read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push(4'd9, 4'd9);
        cpu_read(w, lat);
        check("rst_mask_restored", w, 32'h8000_0099);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
